// File: rtl/seconds_countdown_ctrl_pkg.sv
// Shared definitions for the seconds countdown controller: state encoding and
// default widths/limits.
package seconds_countdown_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        RUN    = 3'd2,
        PAUSE  = 3'd3,
        DONE   = 3'd4
    } cd_state_t;

    localparam int unsigned DEF_SEC_W   = 8;
    localparam int unsigned DEF_MAX_SEC = 99;

endpackage

// File: rtl/seconds_countdown_ctrl.sv
// Loadable seconds countdown that gates an external 1 s tick generator.
// Optional SECONDS_COUNTDOWN_AUTO_RELOAD_EN restarts from the last loaded value on expiry.
module seconds_countdown_ctrl
    import seconds_countdown_ctrl_pkg::*;
#(
    parameter int unsigned SEC_W   = DEF_SEC_W,
    parameter int unsigned MAX_SEC = DEF_MAX_SEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             tick,
    output logic             tick_en,
    output logic [SEC_W-1:0] remaining,
    output logic             running,
    output logic             done,
    output logic             expired
);

    localparam logic [SEC_W-1:0] MAX_V = SEC_W'(MAX_SEC);

    cd_state_t        state_q, state_n;
    logic [SEC_W-1:0] rem_n;
    logic [SEC_W-1:0] clamped;
    logic             exp_n;
    cd_state_t        ld_state;

`ifdef SECONDS_COUNTDOWN_AUTO_RELOAD_EN
    logic [SEC_W-1:0] shadow, shadow_n;
`endif

    always_comb begin
        clamped  = (load_val > MAX_V) ? MAX_V : load_val;
        ld_state = (clamped == '0) ? IDLE : LOADED;
    end

    always_comb begin
        state_n = state_q;
        rem_n   = remaining;
        exp_n   = 1'b0;
`ifdef SECONDS_COUNTDOWN_AUTO_RELOAD_EN
        shadow_n = shadow;
        if (load && clamped != '0 && state_q != RUN)
            shadow_n = clamped;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    state_n = ld_state;
                    rem_n   = clamped;
                end
            end
            LOADED, PAUSE: begin
                if (load) begin
                    state_n = ld_state;
                    rem_n   = clamped;
                end else if (start && !pause) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                // A tick landing together with pause is still counted before pausing.
                if (tick && remaining <= SEC_W'(1)) begin
                    exp_n = 1'b1;
`ifdef SECONDS_COUNTDOWN_AUTO_RELOAD_EN
                    rem_n   = shadow;
                    state_n = pause ? PAUSE : RUN;
`else
                    rem_n   = '0;
                    state_n = DONE;
`endif
                end else if (tick) begin
                    rem_n   = remaining - SEC_W'(1);
                    state_n = pause ? PAUSE : RUN;
                end else if (pause) begin
                    state_n = PAUSE;
                end
            end
            default: begin
                state_n = IDLE;
                rem_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            remaining <= '0;
            tick_en   <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            expired   <= 1'b0;
`ifdef SECONDS_COUNTDOWN_AUTO_RELOAD_EN
            shadow    <= '0;
`endif
        end else begin
            state_q   <= state_n;
            remaining <= rem_n;
            tick_en   <= (state_n == RUN);
            running   <= (state_n == RUN);
            done      <= (state_n == DONE);
            expired   <= exp_n;
`ifdef SECONDS_COUNTDOWN_AUTO_RELOAD_EN
            shadow    <= shadow_n;
`endif
        end
    end

endmodule

// File: tb/tb_seconds_countdown_ctrl.sv
// Self-checking bench for seconds_countdown_ctrl: directed scenarios plus random
// stimulus, all compared every cycle against a string-moded behavioural model.
module tb_seconds_countdown_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       tick = 1'b0;
    logic       tick_en;
    logic [7:0] remaining;
    logic       running;
    logic       done;
    logic       expired;

    int n_vec = 0;
    int n_err = 0;

    string m_mode = "IDLE";
    int    m_rem = 0;
    int    m_shadow = 0;
    bit    m_exp = 1'b0;

    seconds_countdown_ctrl #(.SEC_W(8), .MAX_SEC(99)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .tick(tick),
        .tick_en(tick_en), .remaining(remaining), .running(running),
        .done(done), .expired(expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_load();
        int cl;
        cl = (load_val > 99) ? 99 : int'(load_val);
        if (cl == 0) begin
            m_mode = "IDLE";
            m_rem  = 0;
        end else begin
            m_mode   = "LOADED";
            m_rem    = cl;
            m_shadow = cl;
        end
    endtask

    task automatic model_step();
        m_exp = 1'b0;
        if (!rst) begin
            m_mode = "IDLE"; m_rem = 0; m_shadow = 0;
        end else if (m_mode == "IDLE" || m_mode == "DONE") begin
            if (load) model_load();
        end else if (m_mode == "LOADED" || m_mode == "PAUSE") begin
            if (load) model_load();
            else if (start && !pause) m_mode = "RUN";
        end else if (m_mode == "RUN") begin
            if (tick) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_exp = 1'b1;
`ifdef SECONDS_COUNTDOWN_AUTO_RELOAD_EN
                    m_rem  = m_shadow;
                    m_mode = pause ? "PAUSE" : "RUN";
`else
                    m_mode = "DONE";
`endif
                end else if (pause) begin
                    m_mode = "PAUSE";
                end
            end else if (pause) begin
                m_mode = "PAUSE";
            end
        end
    endtask

    // One clock: inputs as currently driven, then model update and full output compare.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("remaining", 32'(remaining), 32'(m_rem));
        check("tick_en",   32'(tick_en),   32'(m_mode == "RUN"));
        check("running",   32'(running),   32'(m_mode == "RUN"));
        check("done",      32'(done),      32'(m_mode == "DONE"));
        check("expired",   32'(expired),   32'(m_exp));
    endtask

    task automatic drive(input logic l, input logic [7:0] lv, input logic s,
                         input logic p, input logic t);
        load = l; load_val = lv; start = s; pause = p; tick = t;
        step();
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b0;
        idle(2);
        check("reset_rem", 32'(remaining), 32'd0);
        check("reset_ten", 32'(tick_en), 32'd0);
        rst = 1'b1;
        idle(1);

        // reset during RUN with 5 seconds left
        drive(1, 8'd5, 0, 0, 0);
        drive(0, 8'd0, 1, 0, 0);
        check("run_ten", 32'(tick_en), 32'd1);
        rst = 1'b0;
        idle(2);
        check("rst_run_rem", 32'(remaining), 32'd0);
        check("rst_run_ten", 32'(tick_en), 32'd0);
        rst = 1'b1;
        idle(1);

`ifndef SECONDS_COUNTDOWN_AUTO_RELOAD_EN
        // basic count 3 -> 0
        drive(1, 8'd3, 0, 0, 0);
        drive(0, 8'd0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            idle(9);
            drive(0, 8'd0, 0, 0, 1);
        end
        check("basic_exp", 32'(expired), 32'd1);
        check("basic_rem", 32'(remaining), 32'd0);
        idle(1);
        check("basic_exp_once", 32'(expired), 32'd0);
        check("basic_done", 32'(done), 32'd1);
        check("basic_ten", 32'(tick_en), 32'd0);
`endif

        // clamp and zero load
        drive(1, 8'd200, 0, 0, 0);
        check("clamp_rem", 32'(remaining), 32'd99);
        drive(1, 8'd0, 0, 0, 0);
        drive(0, 8'd0, 1, 0, 0);
        check("zero_run", 32'(running), 32'd0);

        // pause discards ticks, resume continues
        drive(1, 8'd5, 0, 0, 0);
        drive(0, 8'd0, 1, 0, 0);
        drive(0, 8'd0, 0, 0, 1);
        drive(0, 8'd0, 0, 0, 1);
        drive(0, 8'd0, 0, 1, 0);
        check("pause_ten", 32'(tick_en), 32'd0);
        for (int k = 0; k < 4; k++) drive(0, 8'd0, 0, 0, 1);
        check("pause_rem", 32'(remaining), 32'd3);
        drive(0, 8'd0, 1, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 8'd0, 0, 0, 1);
        check("resume_exp", 32'(expired), 32'd1);

        // collisions
        drive(1, 8'd7, 0, 0, 0);
        drive(0, 8'd0, 1, 1, 0);
        check("sp_loaded", 32'(running), 32'd0);
        rst = 1'b0; idle(1); rst = 1'b1;
        drive(1, 8'd4, 1, 0, 0);
        check("ls_rem", 32'(remaining), 32'd4);
        check("ls_run", 32'(running), 32'd0);
        drive(1, 8'd1, 0, 0, 0);
        drive(0, 8'd0, 1, 0, 0);
        drive(0, 8'd0, 0, 1, 1);
        check("tp_exp", 32'(expired), 32'd1);

`ifdef SECONDS_COUNTDOWN_AUTO_RELOAD_EN
        // auto-reload: 2,1,2,1,2
        rst = 1'b0; idle(1); rst = 1'b1;
        drive(1, 8'd2, 0, 0, 0);
        drive(0, 8'd0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 8'd0, 0, 0, 1);
            check("ar_rem", 32'(remaining), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("ar_done", 32'(done), 32'd0);
        end
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) != 0);
            load     = ($urandom_range(0, 24) == 0);
            load_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 6));
            start    = ($urandom_range(0, 9) == 0);
            pause    = ($urandom_range(0, 14) == 0);
            tick     = ($urandom_range(0, 3) == 0);
            step();
        end
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
